// File: rtl/register_dump.sv
// ============================================================================
// Module   : register_dump
// Purpose  : Walks every register of a register file once per start request
//            and streams each word out as little-endian bytes over valid/ready.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module register_dump #(
  parameter int AddressBitWidth = 5,
  parameter int DataBitWidth    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic [AddressBitWidth-1:0] reg_addr,
  input  logic [DataBitWidth-1:0]    reg_data,
  output logic [7:0]                 out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       done
);

  localparam int BYTES_PER_WORD = DataBitWidth / 8;
  localparam int IDX_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  localparam logic [IDX_W-1:0]           c_LAST_IDX  = IDX_W'(BYTES_PER_WORD - 1);
  localparam logic [AddressBitWidth-1:0] c_LAST_ADDR = '1;

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_FETCH = 2'd1;
  localparam logic [1:0] c_ST_SEND  = 2'd2;
  localparam logic [1:0] c_ST_DONE  = 2'd3;

  logic [1:0]                 state_q, state_d;
  logic [AddressBitWidth-1:0] addr_q,  addr_d;
  logic [DataBitWidth-1:0]    shift_q, shift_d;
  logic [IDX_W-1:0]           idx_q,   idx_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    case (state_q)
      c_ST_IDLE: begin
        if (start) begin
          addr_d  = '0;
          state_d = c_ST_FETCH;
        end
      end
      c_ST_FETCH: begin
        // The word is captured here only, so later register writes cannot leak into the stream.
        shift_d = reg_data;
        idx_d   = '0;
        state_d = c_ST_SEND;
      end
      c_ST_SEND: begin
        if (out_ready) begin
          shift_d = shift_q >> 8;
          idx_d   = idx_q + 1'b1;
          if (idx_q == c_LAST_IDX) begin
            if (addr_q == c_LAST_ADDR) begin
              state_d = c_ST_DONE;
            end else begin
              addr_d  = addr_q + 1'b1;
              state_d = c_ST_FETCH;
            end
          end
        end
      end
      c_ST_DONE: begin
        state_d = c_ST_IDLE;
      end
      default: begin
        state_d = c_ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= c_ST_IDLE;
      addr_q  <= '0;
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

  // All outputs decode registered state only; out_ready never reaches out_valid.
  assign reg_addr  = addr_q;
  assign out_data  = shift_q[7:0];
  assign out_valid = (state_q == c_ST_SEND);
  assign busy      = (state_q != c_ST_IDLE);
  assign done      = (state_q == c_ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_register_dump.sv
// ============================================================================
// Module   : tb_register_dump
// Purpose  : Scoreboard bench for register_dump with a byte-level reference
//            model, directed scenarios and randomized data/backpressure.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_register_dump;

  localparam int AW     = 5;
  localparam int DW     = 32;
  localparam int NREG   = 32;
  localparam int NBYTES = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          out_ready = 1'b1;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_data;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          busy;
  logic          done;

  logic [DW-1:0] regfile [NREG];
  assign reg_data = regfile[reg_addr];

  register_dump #(
    .AddressBitWidth(AW),
    .DataBitWidth   (DW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .reg_addr (reg_addr),
    .reg_data (reg_data),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         start_edge = 0;
  int         rx_count = 0;
  int         done_count = 0;
  int         done_cycle = 0;
  int         ready_mode = 0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the dump is every register in index order, each word low byte first.
  task automatic push_dump();
    for (int k = 0; k < NREG; k++) begin
      for (int b = 0; b < DW / 8; b++) begin
        exp_q.push_back(regfile[k][8*b +: 8]);
      end
    end
  endtask

  task automatic init_regs();
    for (int k = 0; k < NREG; k++) begin
      regfile[k] = (k == 0) ? 32'h0 : (32'h11223300 + 32'(k));
    end
  endtask

  task automatic issue_start();
    start      = 1'b1;
    start_edge = cyc + 1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int prev, input string name);
    int n = 0;
    while (done_count == prev && n < 3000) begin
      tick();
      n++;
    end
    check({name, "_done_seen"}, 64'(done_count != prev), 64'd1);
  endtask

  task automatic wait_rx(input int target, input string name);
    int n = 0;
    while (rx_count < target && n < 3000) begin
      tick();
      n++;
    end
    check({name, "_rx_reached"}, 64'(rx_count >= target), 64'd1);
  endtask

  // Output-ready driver: steady, alternating or random backpressure.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: observes the stream between edges and retires expected bytes.
  initial begin
    logic       prev_stall;
    logic       prev_done;
    logic [7:0] prev_data;
    prev_stall = 1'b0;
    prev_done  = 1'b0;
    prev_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (prev_stall) check("stall_hold", 64'(out_data), 64'(prev_data));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte: got %0h expected none", out_data);
          end else begin
            check("byte", 64'(out_data), 64'(exp_q.pop_front()));
          end
          rx_count++;
        end
        if (done) begin
          done_count++;
          done_cycle = cyc - start_edge + 1;
          if (prev_done) begin
            checks++;
            errors++;
            $display("FAIL done_width: got 2+ cycles expected 1");
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_done  = done;
      end else begin
        prev_stall = 1'b0;
        prev_done  = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    int rx0;
    int gap;
    int n;

    init_regs();
    rst_n = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_done",      64'(done),      64'd0);
    check("rst_reg_addr",  64'(reg_addr),  64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Basic dump with latency and completion timing.
    push_dump();
    d0 = done_count;
    issue_start();
    @(negedge clk);
    check("fetch_cycle_busy",  64'(busy),      64'd1);
    check("fetch_cycle_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("first_byte_valid",  64'(out_valid), 64'd1);
    check("first_byte_addr",   64'(reg_addr),  64'd0);
    wait_done(d0, "basic");
    check("basic_done_cycle", 64'(done_cycle), 64'd161);
    repeat (3) tick();
    check("basic_done_count", 64'(done_count - d0), 64'd1);
    check("basic_queue_empty", 64'(exp_q.size()), 64'd0);
    check("basic_idle_busy", 64'(busy), 64'd0);

    // Alternating backpressure.
    ready_mode = 1;
    push_dump();
    d0 = done_count;
    issue_start();
    wait_done(d0, "toggle");
    ready_mode = 0;
    repeat (3) tick();
    check("toggle_queue_empty", 64'(exp_q.size()), 64'd0);

    // Register write after its fetch must not reach the stream.
    push_dump();
    d0  = done_count;
    rx0 = rx_count;
    issue_start();
    wait_rx(rx0 + 21, "x5");
    regfile[5] = 32'hDEADBEEF;
    wait_done(d0, "x5");
    regfile[5] = 32'h11223305;
    repeat (3) tick();
    check("x5_queue_empty", 64'(exp_q.size()), 64'd0);

    // Start while busy is ignored.
    push_dump();
    d0  = done_count;
    rx0 = rx_count;
    issue_start();
    repeat (48) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(d0, "restart_ignored");
    repeat (10) tick();
    check("restart_done_count", 64'(done_count - d0), 64'd1);
    check("restart_byte_count", 64'(rx_count - rx0), 64'(NBYTES));

    // Reset in the middle of register 10.
    push_dump();
    d0  = done_count;
    rx0 = rx_count;
    issue_start();
    wait_rx(rx0 + 41, "midreset");
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_busy",      64'(busy),      64'd0);
    check("midreset_reg_addr",  64'(reg_addr),  64'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check("midreset_no_done", 64'(done_count - d0), 64'd0);
    push_dump();
    d0 = done_count;
    issue_start();
    wait_done(d0, "after_reset");
    repeat (3) tick();
    check("after_reset_queue_empty", 64'(exp_q.size()), 64'd0);

    // Start held high: back-to-back dumps with a single idle cycle between them.
    push_dump();
    push_dump();
    d0         = done_count;
    start      = 1'b1;
    start_edge = cyc + 1;
    wait_done(d0, "held_first");
    gap = 0;
    n   = 0;
    @(negedge clk);
    while (!busy && n < 20) begin
      gap++;
      n++;
      @(negedge clk);
    end
    start = 1'b0;
    check("held_idle_gap", 64'(gap), 64'd1);
    wait_done(d0 + 1, "held_second");
    repeat (5) tick();
    check("held_done_count", 64'(done_count - d0), 64'd2);
    check("held_queue_empty", 64'(exp_q.size()), 64'd0);

    // Random register contents under random backpressure.
    ready_mode = 2;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < NREG; k++) regfile[k] = $urandom;
      push_dump();
      d0 = done_count;
      issue_start();
      wait_done(d0, "random");
      repeat (3) tick();
      check("random_queue_empty", 64'(exp_q.size()), 64'd0);
    end
    ready_mode = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/register_dump.md
REGISTER_DUMP -- requirements
Module: register_dump

Interface
REQ-001 SHALL have parameter AddressBitWidth, default 5: register index width; dump covers 2**AddressBitWidth registers.
REQ-002 SHALL have parameter DataBitWidth, default 32: register width; a multiple of 8; BytesPerWord = DataBitWidth/8.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1: request a full dump; sampled only in Idle.
REQ-006 SHALL have port reg_addr  output  AddressBitWidth: register index driven to the register file read port.
REQ-007 SHALL have port reg_data  input  DataBitWidth: combinational read data for reg_addr, valid in the same cycle.
REQ-008 SHALL have port out_data  output  8: byte stream data.
REQ-009 SHALL have port out_valid  output  1: out_data valid.
REQ-010 SHALL have port out_ready  input  1: sink accepts the byte; a transfer occurs when out_valid and out_ready are both 1 at a rising edge.
REQ-011 SHALL have port busy  output  1: high whenever state is not Idle.
REQ-012 SHALL have port done  output  1: one-cycle pulse at dump completion.

Function
REQ-013 SHALL implement FSM states Idle, Fetch, Send and Done.
REQ-014 In Idle with start=1: SHALL set reg_addr=0 and go to Fetch; start=0 stays Idle.
REQ-015 In Fetch: SHALL latch reg_data into a DataBitWidth shift word, clear the byte index, and go to Send.
REQ-016 Latch timing: data SHALL be latched exactly once per register; register-file writes after the Fetch cycle SHALL NOT alter the bytes emitted.
REQ-017 In Send: SHALL drive out_valid=1 and out_data=shift word bits [7:0]; bytes go out little-endian.
REQ-018 On a Send transfer: SHALL shift the word right 8 bits and increment the byte index.
REQ-019 Last-byte transfer, reg_addr below 2**AddressBitWidth-1: SHALL increment reg_addr and go to Fetch.
REQ-020 Last-byte transfer, reg_addr = 2**AddressBitWidth-1: SHALL go to Done; reg_addr SHALL NOT wrap.
REQ-021 Backpressure: while out_valid=1 and out_ready=0, out_data and state SHALL hold unchanged.
REQ-022 out_valid SHALL be 0 in Idle, Fetch and Done; no combinational path from out_ready to out_valid.
REQ-023 In Done: SHALL assert done=1 for exactly one cycle, then go to Idle.
REQ-024 start while busy (including in Done) SHALL be ignored; start=1 held in Idle SHALL begin a new dump.
REQ-025 Latency, start sampled at edge 0 with out_ready=1: Fetch in cycle 1, first valid byte in cycle 2.
REQ-026 Per-register cost with out_ready=1: 1 + BytesPerWord cycles; defaults give 160 cycles of Fetch/Send and done in cycle 161.
REQ-027 reg_addr SHALL hold its value throughout Fetch and Send of that register.

Reset
REQ-028 rst_n=0 at a rising edge: SHALL force state Idle, reg_addr=0, out_valid=0, out_data=0, busy=0, done=0, shift word=0, byte index=0.
REQ-029 Reset SHALL take priority over start and over any in-flight transfer; a reset mid-dump SHALL abandon the dump with no done pulse.

Verification
REQ-030 Reg file x0=0, xk=0x11223300+k, out_ready=1, pulse start -> 128 bytes: 00 00 00 00, then 01 33 22 11, ..., last 1F 33 22 11; done=1 in cycle 161 only.
REQ-031 out_ready toggling 1/0 each cycle -> byte sequence identical to REQ-030; out_data stable during every stall.
REQ-032 Write x5=0xDEADBEEF during Send of x5 (value 0x11223305 at Fetch) -> 05 33 22 11 emitted for x5.
REQ-033 Assert start again at cycle 50 -> ignored; exactly 128 bytes and a single done pulse.
REQ-034 rst_n=0 during Send of x10 -> next cycle out_valid=0, busy=0, reg_addr=0; no done; a following start restarts from x0.
REQ-035 start held high continuously -> back-to-back dumps; busy=0 for exactly one cycle between done and the next Fetch.
